// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: unit codes, default latencies and the
// result-slot record, so Issue, the functional units and Writeback agree on them.
package issue_scoreboard_pkg;

  localparam logic [1:0] UNIT_NONE = 2'd0;
  localparam logic [1:0] UNIT_AM   = 2'd1;
  localparam logic [1:0] UNIT_MEM  = 2'd2;
  localparam logic [1:0] UNIT_MUL  = 2'd3;

  localparam int SB_DEPTH    = 8;
  localparam int AM_LAT_DEF  = 4;
  localparam int MEM_LAT_DEF = 3;
  localparam int MUL_LAT_DEF = 6;

  localparam int REG_W = 5;

  typedef struct packed {
    logic [1:0]       unit;
    logic             writereg;
    logic [REG_W-1:0] regdest;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/issue_scoreboard_result_shift_reg.sv
// Result shift register: one slot per future writeback cycle, shifting toward slot 0
// every cycle, with a single indexed load that takes priority over the shift.
module issue_scoreboard_result_shift_reg
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_en,
  input  logic [IW-1:0]       load_idx,
  input  slot_t               load_data,
  output slot_t [DEPTH-1:0]   slots,
  output logic  [DEPTH-1:0]   occupied
);

  // NOTE: the slots carry the valid state of in-flight ops, so unlike a data RAM they must be reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slots <= '0;
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slots[k] <= slots[k+1];
      end
      slots[DEPTH-1] <= SLOT_EMPTY;
      // NOTE: non-blocking only; the later load assignment to the same slot overrides the shift.
      if (load_en) begin
        slots[load_idx] <= load_data;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_occ
    assign occupied[k] = (slots[k].unit != UNIT_NONE);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard responder: RAW/WAW/result-bus stall decision, writeback-slot
// reservation, pending-destination bitmap and a sticky writeback consistency check.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH   = SB_DEPTH,
  parameter int AM_LAT  = AM_LAT_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_sb_req,
  input  logic [1:0]  iss_sb_unit,
  input  logic        iss_sb_rega_used,
  input  logic [4:0]  iss_sb_addra,
  input  logic        iss_sb_regb_used,
  input  logic [4:0]  iss_sb_addrb,
  input  logic        iss_sb_writereg,
  input  logic [4:0]  iss_sb_regdest,
  output logic        sb_iss_stall,
  output logic [1:0]  sb_wb_unit,
  output logic        sb_wb_writereg,
  output logic [4:0]  sb_wb_regdest,
  input  logic        wb_sb_en,
  input  logic [4:0]  wb_sb_addr,
  output logic [31:0] sb_pending,
  output logic        sb_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  if (AM_LAT < 1 || AM_LAT > DEPTH || MEM_LAT < 1 || MEM_LAT > DEPTH ||
      MUL_LAT < 1 || MUL_LAT > DEPTH) begin : g_bad_latency
    $error("issue_scoreboard: every unit latency must lie in 1..DEPTH");
  end

  slot_t [DEPTH-1:0] slots;
  logic  [DEPTH-1:0] occupied;
  logic  [DEPTH:0]   occ_ext;
  logic  [LW-1:0]    lat;
  logic  [IW-1:0]    load_idx;
  logic              load_en;
  logic              accept;
  logic              raw_hz, waw_hz, struct_hz;
  logic  [31:0]      pend_q, pend_d;
  logic              err_now;
  slot_t             s0;

  always_comb begin
    case (iss_sb_unit)
      UNIT_AM:  lat = LW'(AM_LAT);
      UNIT_MEM: lat = LW'(MEM_LAT);
      UNIT_MUL: lat = LW'(MUL_LAT);
      default:  lat = '0;
    endcase
  end

  // A slot index of DEPTH reads the constant-empty top bit, so L==DEPTH never collides.
  assign occ_ext   = {1'b0, occupied};
  assign raw_hz    = (iss_sb_rega_used & pend_q[iss_sb_addra]) |
                     (iss_sb_regb_used & pend_q[iss_sb_addrb]);
  assign waw_hz    = iss_sb_writereg & (iss_sb_regdest != '0) & pend_q[iss_sb_regdest];
  assign struct_hz = (iss_sb_unit != UNIT_NONE) & occ_ext[lat];

  assign sb_iss_stall = iss_sb_req & (raw_hz | waw_hz | struct_hz);
  assign accept       = iss_sb_req & ~sb_iss_stall;
  assign load_en      = accept & (iss_sb_unit != UNIT_NONE);
  assign load_idx     = IW'(lat - LW'(1));

  issue_scoreboard_result_shift_reg #(.DEPTH(DEPTH)) u_rsr (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data ('{unit: iss_sb_unit, writereg: iss_sb_writereg, regdest: iss_sb_regdest}),
    .slots     (slots),
    .occupied  (occupied)
  );

  assign s0 = slots[0];

  // NOTE: pend_d starts from pend_q so every path assigns it and no latch is inferred.
  always_comb begin
    pend_d = pend_q;
    if (s0.unit != UNIT_NONE && s0.writereg) begin
      pend_d[s0.regdest] = 1'b0;
    end
    if (load_en && iss_sb_writereg && iss_sb_regdest != '0) begin
      pend_d[iss_sb_regdest] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // An ALU/misc slot may legally skip its write (overflow suppression); a wrong address never is.
  assign err_now = (s0.writereg & ~wb_sb_en & (s0.unit != UNIT_AM)) |
                   (s0.writereg & wb_sb_en & (wb_sb_addr != s0.regdest)) |
                   (wb_sb_en & ~s0.writereg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      sb_err <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (err_now) begin
        sb_err <= 1'b1;
      end
    end
  end

  assign sb_pending     = pend_q;
  assign sb_wb_unit     = s0.unit;
  assign sb_wb_writereg = s0.writereg;
  assign sb_wb_regdest  = s0.regdest;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a cycle-by-cycle vector table with hand-computed
// expectations, plus hand-written reset and error sequences.
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_sb_req;
  logic [1:0]  iss_sb_unit;
  logic        iss_sb_rega_used;
  logic [4:0]  iss_sb_addra;
  logic        iss_sb_regb_used;
  logic [4:0]  iss_sb_addrb;
  logic        iss_sb_writereg;
  logic [4:0]  iss_sb_regdest;
  logic        sb_iss_stall;
  logic [1:0]  sb_wb_unit;
  logic        sb_wb_writereg;
  logic [4:0]  sb_wb_regdest;
  logic        wb_sb_en;
  logic [4:0]  wb_sb_addr;
  logic [31:0] sb_pending;
  logic        sb_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        req;
    logic [1:0]  unit;
    logic        rau;
    logic [4:0]  ra;
    logic        rbu;
    logic [4:0]  rb;
    logic        wr;
    logic [4:0]  rd;
    logic        wben;
    logic [4:0]  wba;
    logic        e_stall;
    logic [1:0]  e_wbu;
    logic        e_wbwr;
    logic [4:0]  e_wbrd;
    logic [31:0] e_pend;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  issue_scoreboard dut (
    .clock            (clock),
    .reset            (reset),
    .iss_sb_req       (iss_sb_req),
    .iss_sb_unit      (iss_sb_unit),
    .iss_sb_rega_used (iss_sb_rega_used),
    .iss_sb_addra     (iss_sb_addra),
    .iss_sb_regb_used (iss_sb_regb_used),
    .iss_sb_addrb     (iss_sb_addrb),
    .iss_sb_writereg  (iss_sb_writereg),
    .iss_sb_regdest   (iss_sb_regdest),
    .sb_iss_stall     (sb_iss_stall),
    .sb_wb_unit       (sb_wb_unit),
    .sb_wb_writereg   (sb_wb_writereg),
    .sb_wb_regdest    (sb_wb_regdest),
    .wb_sb_en         (wb_sb_en),
    .wb_sb_addr       (wb_sb_addr),
    .sb_pending       (sb_pending),
    .sb_err           (sb_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic [1:0] unit, input logic rau, input logic [4:0] ra,
                     input logic rbu, input logic [4:0] rb, input logic wr, input logic [4:0] rd,
                     input logic wben, input logic [4:0] wba, input logic e_stall,
                     input logic [1:0] e_wbu, input logic e_wbwr, input logic [4:0] e_wbrd,
                     input logic [31:0] e_pend, input logic e_err);
    vec_t v;
    v.req = req; v.unit = unit; v.rau = rau; v.ra = ra; v.rbu = rbu; v.rb = rb;
    v.wr = wr; v.rd = rd; v.wben = wben; v.wba = wba; v.e_stall = e_stall;
    v.e_wbu = e_wbu; v.e_wbwr = e_wbwr; v.e_wbrd = e_wbrd; v.e_pend = e_pend; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [31:0] e_pend, input logic e_err);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pend, e_err);
  endtask

  task automatic drive(input vec_t v);
    iss_sb_req       = v.req;
    iss_sb_unit      = v.unit;
    iss_sb_rega_used = v.rau;
    iss_sb_addra     = v.ra;
    iss_sb_regb_used = v.rbu;
    iss_sb_addrb     = v.rb;
    iss_sb_writereg  = v.wr;
    iss_sb_regdest   = v.rd;
    wb_sb_en         = v.wben;
    wb_sb_addr       = v.wba;
  endtask

  task automatic drive_idle();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("idle%0d stall", i), 32'(sb_iss_stall), 0);
      check($sformatf("idle%0d pending", i), sb_pending, 0);
      check($sformatf("idle%0d wb_unit", i), 32'(sb_wb_unit), 0);
      check($sformatf("idle%0d err", i), 32'(sb_err), 0);
    end

    // AM rd=5: pending cycles 1..4, writeback cycle 4
    add(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    repeat (3) idle(32'h20, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 1, 5, 32'h20, 0);
    idle(32'h0, 0);

    // Mult rd=3 then AM reading r3: RAW stall cycles 1..6, accept cycle 7
    add(1, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    repeat (5) add(1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0, 32'h8, 0);
    add(1, 1, 1, 3, 0, 0, 1, 4, 1, 3, 1, 3, 1, 3, 32'h8, 0);
    add(1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    repeat (3) idle(32'h10, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h10, 0);
    idle(32'h0, 0);

    // Mult rd=10 then AM rd=11 two cycles later: result-bus stall, accept next cycle
    add(1, 3, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(32'h400, 0);
    add(1, 1, 0, 0, 0, 0, 1, 11, 0, 0, 1, 0, 0, 0, 32'h400, 0);
    add(1, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 32'h400, 0);
    repeat (2) idle(32'hC00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 3, 1, 10, 32'hC00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 1, 1, 11, 32'h800, 0);
    idle(32'h0, 0);

    // WAW on r7, structural stall for an rd=0 Mem op, RAW via rt, nop reading r0
    add(1, 2, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    repeat (2) add(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 32'h80, 0);
    add(1, 1, 0, 0, 0, 0, 1, 7, 1, 7, 1, 2, 1, 7, 32'h80, 0);
    add(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    add(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h80, 0);
    add(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0);
    add(1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 32'h80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 7, 32'h80, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 32'h0, 0);
    repeat (3) idle(32'h0, 0);

    // Writeback address mismatch -> sticky error
    add(1, 2, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    repeat (2) idle(32'h100, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 2, 1, 8, 32'h100, 0);
    repeat (3) idle(32'h0, 1);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d stall", i), 32'(sb_iss_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d wb_unit", i), 32'(sb_wb_unit), 32'(vecs[i].e_wbu));
      check($sformatf("v%0d wb_writereg", i), 32'(sb_wb_writereg), 32'(vecs[i].e_wbwr));
      check($sformatf("v%0d wb_regdest", i), 32'(sb_wb_regdest), 32'(vecs[i].e_wbrd));
      check($sformatf("v%0d pending", i), sb_pending, vecs[i].e_pend);
      check($sformatf("v%0d err", i), 32'(sb_err), 32'(vecs[i].e_err));
    end

    // Reset mid-flight discards a Mult reservation and the sticky error
    @(negedge clock);
    iss_sb_req = 1'b1; iss_sb_unit = 2'd3; iss_sb_writereg = 1'b1; iss_sb_regdest = 5'd12;
    wb_sb_en = 1'b0;
    #1;
    check("rst mult accept", 32'(sb_iss_stall), 0);
    @(negedge clock);
    drive_idle();
    #1;
    check("rst pending before", sb_pending, 32'h1000);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst pending", sb_pending, 0);
    check("rst err", 32'(sb_err), 0);
    check("rst wb_unit", 32'(sb_wb_unit), 0);
    check("rst wb_regdest", 32'(sb_wb_regdest), 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("post rst%0d wb_unit", i), 32'(sb_wb_unit), 0);
      check($sformatf("post rst%0d pending", i), sb_pending, 0);
    end

    // Writeback enable with nothing reserved is an error
    @(negedge clock);
    wb_sb_en = 1'b1; wb_sb_addr = 5'd2;
    #1;
    check("spurious wb err before", 32'(sb_err), 0);
    @(negedge clock);
    wb_sb_en = 1'b0;
    #1;
    check("spurious wb err", 32'(sb_err), 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("final rst err", 32'(sb_err), 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
